// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IF and LS (ports: clk/rst, if_*, ls_*, mem_*; `define MEM_ARB_RR_EN for round-robin)
module mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_resp_valid,
  input  logic            if_resp_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_we,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_resp_valid,
  input  logic            ls_resp_ready,
  output logic [DW-1:0]   ls_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic owner_ls, we_q, pick_ls, accept, resp_fire;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [3:0] cnt;
`ifdef MEM_ARB_RR_EN
  logic last_ls;
  always_ff @(posedge clk)
    if (rst) last_ls <= 1'b0;
    else if (accept) last_ls <= pick_ls;
  assign pick_ls = ls_req_valid && (!if_req_valid || !last_ls);
`else
  assign pick_ls = ls_req_valid;
`endif
  assign accept = if_req_ready || ls_req_ready;
  assign resp_fire = state == RESP && (owner_ls ? ls_resp_ready : if_resp_ready);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (accept ? ISSUE : IDLE) :
              state == ISSUE ? (LATENCY == 0 ? RESP : WAIT) :
              state == WAIT  ? (cnt == 4'(LATENCY - 1) ? RESP : WAIT) :
                               (resp_fire ? IDLE : RESP);
  always_comb begin
    ls_req_ready  = state == IDLE && pick_ls;
    if_req_ready  = state == IDLE && if_req_valid && !pick_ls;
    mem_ce        = state == ISSUE;
    mem_we        = mem_ce && we_q;
    mem_wmask     = mem_we ? wmask_q : '0;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    if_resp_valid = state == RESP && !owner_ls;
    ls_resp_valid = state == RESP && owner_ls;
    if_rdata      = rdata_q;
    ls_rdata      = rdata_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        owner_ls <= pick_ls;
        addr_q   <= pick_ls ? ls_addr : if_addr;
        we_q     <= pick_ls && ls_we;
        wdata_q  <= pick_ls ? ls_wdata : '0;
        wmask_q  <= pick_ls ? ls_wmask : '0;
      end
      if (state == ISSUE) begin
        rdata_q <= we_q ? '0 : mem_rdata;
        cnt     <= '0;
      end
      if (state == WAIT) cnt <= cnt + 4'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level memory model
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LAT = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready, if_resp_valid, if_resp_ready;
  logic ls_req_valid = 1'b0, ls_req_ready, ls_resp_valid, ls_resp_ready;
  logic ls_we = 1'b0, mem_ce, mem_we;
  logic [AW-1:0] if_addr = '0, ls_addr = '0, mem_addr;
  logic [DW-1:0] if_rdata, ls_rdata, ls_wdata = '0, mem_wdata, mem_rdata;
  logic [7:0] ls_wmask = '0, mem_wmask;
  mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [63:0] mem [256];
  logic [63:0] rmem [256];
  assign mem_rdata = mem[mem_addr[10:3]];
  always @(posedge clk)
    if (mem_ce && mem_we)
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) mem[mem_addr[10:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  typedef struct {
    bit ls;
    logic [63:0] addr;
    bit we;
    logic [7:0] wmask;
    logic [63:0] data;
    int exp_cyc;
  } txn_t;
  txn_t q[$];
  int checks = 0;
  int errors = 0;
  bit last_ls = 1'b0;
  bit skip = 1'b1;
  bit seen = 1'b0;
  int ce_cnt = 0;
  int hold_if = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic do_req(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                        input bit we, input logic [63:0] wd, input logic [7:0] wm);
    bit exp_ls, got;
    txn_t t;
    logic [7:0] idx;
    @(posedge clk);
    #1;
    if_req_valid = iv; if_addr = ia;
    ls_req_valid = lv; ls_addr = la; ls_we = we; ls_wdata = wd; ls_wmask = wm;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = if_req_ready || ls_req_ready;
    end
    if (!got) begin
      errors++;
      $display("FAIL req_timeout got no ready expected ready within 300 cycles");
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      return;
    end
`ifdef MEM_ARB_RR_EN
    exp_ls = lv && (!iv || !last_ls);
`else
    exp_ls = lv;
`endif
    chk("grant_ls", ls_req_ready, exp_ls);
    chk("grant_if", if_req_ready, !exp_ls);
    last_ls = exp_ls;
    t.ls = exp_ls;
    t.addr = exp_ls ? la : ia;
    t.we = exp_ls && we;
    t.wmask = t.we ? wm : 8'h0;
    idx = t.addr[10:3];
    if (t.we) begin
      t.data = '0;
      for (int b = 0; b < 8; b++) if (wm[b]) rmem[idx][b*8 +: 8] = wd[b*8 +: 8];
    end else t.data = rmem[idx];
    t.exp_cyc = cyc + 2 + LAT;
    q.push_back(t);
    @(posedge clk);
    #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  initial begin
    if_resp_ready = 1'b0; ls_resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if_resp_ready = hold_if > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      ls_resp_ready = $urandom_range(0, 3) != 0;
      if (hold_if > 0) hold_if--;
    end
  end
  initial forever begin
    @(negedge clk);
    if (!skip && !rst) begin
      chk("one_resp", {63'd0, if_resp_valid && ls_resp_valid}, 0);
      if (mem_ce) begin
        if (q.size() == 0) chk("ce_unexpected", 1, 0);
        else begin
          chk("ce_addr", mem_addr, q[0].addr);
          chk("ce_we", mem_we, q[0].we);
          chk("ce_mask", mem_wmask, q[0].wmask);
          chk("ce_cycle", cyc, q[0].exp_cyc - 1 - LAT);
          ce_cnt++;
        end
      end else chk("idle_we_mask", {mem_we, mem_wmask}, 0);
      if (if_resp_valid || ls_resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          chk("resp_owner", ls_resp_valid, q[0].ls);
          chk("resp_data", q[0].ls ? ls_rdata : if_rdata, q[0].data);
          chk("resp_req_ready", if_req_ready || ls_req_ready, 0);
          if (!seen) begin
            chk("resp_latency", cyc, q[0].exp_cyc);
            seen = 1'b1;
          end
          if (q[0].ls ? ls_resp_ready : if_resp_ready) begin
            chk("ce_pulses", ce_cnt, 1);
            void'(q.pop_front());
            seen = 1'b0;
            ce_cnt = 0;
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bit iv, lv;
    for (int i = 0; i < 256; i++) begin
      rmem[i] = {$urandom, $urandom};
      mem[i] = rmem[i];
    end
    rmem[0] = 64'h0000_0013_0000_0093;
    mem[0] = rmem[0];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valids", {if_resp_valid, ls_resp_valid, mem_ce, mem_we, if_req_ready, ls_req_ready}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_rdata", if_rdata, 0);
    skip = 1'b0;
    do_req(1, 0, BASE, 0, 0, 0, 0);
    do_req(0, 1, 0, BASE + 64'h100, 1, 64'hDEADBEEF_CAFEF00D, 8'h0F);
    do_req(0, 1, 0, BASE + 64'h100, 0, 0, 0);
    drain();
    chk("ls_read_back_low", rmem[32][31:0], 32'hCAFEF00D);
    repeat (4) do_req(1, 1, BASE + 64'h8, BASE + 64'h10, 0, 0, 0);
    hold_if = LAT + 9;
    do_req(1, 0, BASE + 64'h18, 0, 0, 0, 0);
    do_req(0, 1, 0, BASE + 64'h20, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) iv = 1'b1;
      do_req(iv, lv, BASE + 64'($urandom_range(0, 47) * 8), BASE + 64'($urandom_range(0, 47) * 8),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
    end
    drain();
    do_req(1, 0, BASE + 64'h28, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    skip = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    seen = 1'b0;
    ce_cnt = 0;
    last_ls = 1'b0;
    if_req_valid = 1'b1;
    if_addr = BASE;
    @(negedge clk);
    chk("rst_mid_quiet", {if_resp_valid, ls_resp_valid, mem_ce}, 0);
    chk("rst_mid_idle", if_req_ready, 1);
    if_req_valid = 1'b0;
    skip = 1'b0;
    do_req(1, 0, BASE + 64'h30, 0, 0, 0, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
